// File: rtl/nrisc_pc_unit.sv
// NRISC program-counter / fetch unit: PC register, call/return stack of {return PC, flags},
// registered instruction capture and sticky stack-error reporting.
module nrisc_pc_unit #(
  parameter int              TAM        = 16,
  parameter int              NStack     = 8,
  parameter int              FLAGW      = 3,
  parameter logic [TAM-1:0]  RST_VECTOR = {TAM{1'b0}}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    pc_op,
  input  logic [TAM-1:0]                target,
  input  logic [TAM-1:0]                offset,
  input  logic [FLAGW-1:0]              flags_in,
  input  logic                          mem_ack,
  input  logic [TAM-1:0]                Instruction,
  input  logic                          err_clear,
  output logic [TAM-1:0]                ProgADDR,
  output logic [TAM-1:0]                IR,
  output logic                          ir_valid,
  output logic [FLAGW-1:0]              flags_restore,
  output logic                          flags_restore_valid,
  output logic [$clog2(NStack+1)-1:0]   stack_depth,
  output logic                          stack_full,
  output logic                          stack_empty,
  output logic                          err_overflow,
  output logic                          err_underflow
);

  localparam int DW = $clog2(NStack + 1);
  localparam int IW = $clog2(NStack);
  localparam int EW = TAM + FLAGW;
  localparam logic [DW-1:0] FULL_DEPTH = DW'(NStack);

  localparam logic [2:0] OP_NEXT   = 3'b000;
  localparam logic [2:0] OP_HOLD   = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;
  localparam logic [2:0] OP_BRANCH = 3'b101;

  logic [TAM-1:0]   pc_r, ir_r;
  logic             ir_valid_r;
  logic [FLAGW-1:0] fr_r;
  logic             frv_r;
  logic [DW-1:0]    depth_r;
  logic             err_ov_r, err_un_r;
  logic [EW-1:0]    stack_mem_r [NStack];

  logic [TAM-1:0]   pc_plus1_s, pc_nxt_s;
  logic [DW-1:0]    depth_nxt_s, depth_m1_s;
  logic [IW-1:0]    push_idx_s, pop_idx_s;
  logic [EW-1:0]    top_s;
  logic             full_s, empty_s, push_s;
  logic [FLAGW-1:0] fr_nxt_s;
  logic             frv_nxt_s, ov_evt_s, un_evt_s, err_ov_nxt_s, err_un_nxt_s;

  assign full_s     = (depth_r == FULL_DEPTH);
  assign empty_s    = (depth_r == {DW{1'b0}});
  assign pc_plus1_s = pc_r + {{(TAM-1){1'b0}}, 1'b1};
  assign depth_m1_s = depth_r - {{(DW-1){1'b0}}, 1'b1};
  assign push_idx_s = depth_r[IW-1:0];
  assign pop_idx_s  = depth_m1_s[IW-1:0];
  assign top_s      = stack_mem_r[pop_idx_s];

  // Next PC, stack movement and error events; nothing moves unless memory acknowledged the fetch
  always_comb begin
    pc_nxt_s    = pc_r;
    depth_nxt_s = depth_r;
    push_s      = 1'b0;
    fr_nxt_s    = fr_r;
    frv_nxt_s   = 1'b0;
    ov_evt_s    = 1'b0;
    un_evt_s    = 1'b0;
    if (mem_ack) begin
      case (pc_op)
        OP_NEXT:   pc_nxt_s = pc_plus1_s;
        OP_HOLD:   pc_nxt_s = pc_r;
        OP_JUMP:   pc_nxt_s = target;
        OP_BRANCH: pc_nxt_s = pc_r + offset;
        OP_CALL: begin
          if (full_s) begin
            pc_nxt_s = pc_plus1_s;
            ov_evt_s = 1'b1;
          end else begin
            pc_nxt_s    = target;
            push_s      = 1'b1;
            depth_nxt_s = depth_r + {{(DW-1){1'b0}}, 1'b1};
          end
        end
        OP_RET: begin
          if (empty_s) begin
            pc_nxt_s = pc_plus1_s;
            un_evt_s = 1'b1;
          end else begin
            pc_nxt_s    = top_s[EW-1:FLAGW];
            fr_nxt_s    = top_s[FLAGW-1:0];
            frv_nxt_s   = 1'b1;
            depth_nxt_s = depth_m1_s;
          end
        end
        default:   pc_nxt_s = pc_r;
      endcase
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // Sticky errors: a new error on the same edge beats err_clear
  always_comb begin
    err_ov_nxt_s = err_ov_r;
    err_un_nxt_s = err_un_r;
    if (ov_evt_s) begin
      err_ov_nxt_s = 1'b1;
    end else if (err_clear) begin
      err_ov_nxt_s = 1'b0;
    end else begin
      err_ov_nxt_s = err_ov_r;
    end
    if (un_evt_s) begin
      err_un_nxt_s = 1'b1;
    end else if (err_clear) begin
      err_un_nxt_s = 1'b0;
    end else begin
      err_un_nxt_s = err_un_r;
    end
  end

  // Control and status state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r       <= RST_VECTOR;
      ir_r       <= {TAM{1'b0}};
      ir_valid_r <= 1'b0;
      fr_r       <= {FLAGW{1'b0}};
      frv_r      <= 1'b0;
      depth_r    <= {DW{1'b0}};
      err_ov_r   <= 1'b0;
      err_un_r   <= 1'b0;
    end else begin
      pc_r       <= pc_nxt_s;
      ir_r       <= mem_ack ? Instruction : ir_r;
      ir_valid_r <= mem_ack;
      fr_r       <= fr_nxt_s;
      frv_r      <= frv_nxt_s;
      depth_r    <= depth_nxt_s;
      err_ov_r   <= err_ov_nxt_s;
      err_un_r   <= err_un_nxt_s;
    end
  end

  // Stack storage has no reset; entries above stack_depth are meaningless
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_mem_r[push_idx_s] <= {pc_plus1_s, flags_in};
    end
  end

  assign ProgADDR            = pc_r;
  assign IR                  = ir_r;
  assign ir_valid            = ir_valid_r;
  assign flags_restore       = fr_r;
  assign flags_restore_valid = frv_r;
  assign stack_depth         = depth_r;
  assign stack_full          = full_s;
  assign stack_empty         = empty_s;
  assign err_overflow        = err_ov_r;
  assign err_underflow       = err_un_r;

endmodule
